// File: rtl/life_pkg.sv
// Shared types and constants for the life board front-panel controller.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLIP,
        FLIP_D,
        NXT,
        BUSY
    } state_e;

    localparam int BTN_N     = 6;
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_FLIP  = 4;
    localparam int BTN_NXT   = 5;

endpackage

// File: rtl/life_debounce.sv
// Button front end: 2-FF synchroniser, prescaled sampler and rising-edge detect for all buttons.
module life_debounce
    import life_pkg::*;
#(
    parameter int DEB_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BTN_N-1:0] btn_raw,
    output logic             tick,
    output logic [BTN_N-1:0] press,
    output logic [BTN_N-1:0] synced
);

    logic [BTN_N-1:0]    sync1_q;
    logic [BTN_N-1:0]    sync2_q;
    logic [BTN_N-1:0]    samp_q;
    logic [BTN_N-1:0]    samp_d;
    logic [DEB_BITS-1:0] presc_q;

    // Everything resets to "pressed" so a button held through reset never produces an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            samp_q  <= '1;
            presc_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = &presc_q;

    always_comb begin
        samp_d = samp_q;
        if (tick) begin
            samp_d = sync2_q;
        end
    end

    assign press  = {BTN_N{tick}} & sync2_q & ~samp_q;
    assign synced = sync2_q;

endmodule

// File: rtl/life_keys.sv
// Front-panel controller: debounced buttons drive a wrapping cursor and flip/nxt key pulses.
// Optional auto-run mode is compiled in with LIFE_KEYS_AUTORUN_EN.
//
//   state  | meaning
//   IDLE   | waiting for a button event, cursor may move on a tick
//   FLIP   | key_flip high
//   FLIP_D | key_flip_d high, pending flip cleared
//   NXT    | key_nxt high
//   BUSY   | core computing a generation, flips are queued one deep
module life_keys
    import life_pkg::*;
#(
    parameter int X         = 8,
    parameter int Y         = 8,
    parameter int LOG2X     = 3,
    parameter int LOG2Y     = 3,
    parameter int DEB_BITS  = 16,
    parameter int AUTO_BITS = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_flip,
    input  logic             btn_nxt,
    input  logic             nxt_bit,
    output logic             key_flip,
    output logic             key_flip_d,
    output logic             key_nxt,
    output logic [LOG2X-1:0] cursor_x,
    output logic [LOG2Y-1:0] cursor_y
);

    logic             tick;
    logic [BTN_N-1:0] press;
    logic [BTN_N-1:0] synced;
    logic [BTN_N-1:0] btn_raw;

    state_e           state_q, state_d;
    logic             flip_pend_q, flip_pend_d;
    logic [LOG2X-1:0] cx_q, cx_d, x_step;
    logic [LOG2Y-1:0] cy_q, cy_d, y_step;
    logic             kf_q, kfd_q, kn_q;
    logic             flip_evt;
    logic             nxt_evt;

    assign btn_raw = {btn_nxt, btn_flip, btn_down, btn_up, btn_right, btn_left};

    life_debounce #(
        .DEB_BITS(DEB_BITS)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .tick   (tick),
        .press  (press),
        .synced (synced)
    );

    assign flip_evt = press[BTN_FLIP];

`ifdef LIFE_KEYS_AUTORUN_EN
    localparam int HOLD_TICKS = 16;

    logic                 auto_q, auto_d;
    logic [4:0]           hold_q, hold_d;
    logic [AUTO_BITS-1:0] per_q, per_d;

    // A press while in auto mode only leaves auto mode; the hold counter is parked
    // at saturation so the same long press cannot re-enter it.
    always_comb begin
        auto_d  = auto_q;
        hold_d  = hold_q;
        per_d   = '1;
        nxt_evt = 1'b0;
        if (auto_q) begin
            if (per_q == '0) begin
                nxt_evt = 1'b1;
            end else begin
                per_d = per_q - 1'b1;
            end
        end
        if (tick) begin
            if (!synced[BTN_NXT]) begin
                hold_d = '0;
            end else if (hold_q < 5'(HOLD_TICKS)) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == 5'(HOLD_TICKS - 1)) begin
                    auto_d = ~auto_q;
                end
            end
        end
        if (press[BTN_NXT]) begin
            if (auto_q) begin
                auto_d  = 1'b0;
                hold_d  = 5'(HOLD_TICKS);
                nxt_evt = 1'b0;
            end else begin
                nxt_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_q <= 1'b0;
            hold_q <= '0;
            per_q  <= '1;
        end else begin
            auto_q <= auto_d;
            hold_q <= hold_d;
            per_q  <= per_d;
        end
    end
`else
    logic [BTN_N-1:0]     unused_synced;
    logic [AUTO_BITS-1:0] unused_auto;

    assign nxt_evt       = press[BTN_NXT];
    assign unused_synced = synced;
    assign unused_auto   = '0;
`endif

    // Opposite moves on one axis cancel; the two axes move independently.
    always_comb begin
        x_step = cx_q;
        y_step = cy_q;
        if (press[BTN_LEFT] && !press[BTN_RIGHT]) begin
            x_step = (cx_q == '0) ? LOG2X'(X - 1) : cx_q - 1'b1;
        end else if (press[BTN_RIGHT] && !press[BTN_LEFT]) begin
            x_step = (cx_q == LOG2X'(X - 1)) ? '0 : cx_q + 1'b1;
        end
        if (press[BTN_UP] && !press[BTN_DOWN]) begin
            y_step = (cy_q == '0) ? LOG2Y'(Y - 1) : cy_q - 1'b1;
        end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
            y_step = (cy_q == LOG2Y'(Y - 1)) ? '0 : cy_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        flip_pend_d = flip_pend_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        case (state_q)
            IDLE: begin
                if (flip_evt || flip_pend_q) begin
                    state_d = FLIP;
                end else begin
                    if (nxt_evt) begin
                        state_d = NXT;
                    end
                    if (tick) begin
                        cx_d = x_step;
                        cy_d = y_step;
                    end
                end
            end
            FLIP:   state_d = FLIP_D;
            FLIP_D: begin
                flip_pend_d = 1'b0;
                state_d     = IDLE;
            end
            NXT:    state_d = BUSY;
            BUSY: begin
                if (flip_evt) begin
                    flip_pend_d = 1'b1;
                end
                // Leaving BUSY goes straight to FLIP when one is queued, so the
                // flip follows the core going idle by a single clock.
                if (!nxt_bit) begin
                    state_d = (flip_evt || flip_pend_q) ? FLIP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            flip_pend_q <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            kf_q        <= 1'b0;
            kfd_q       <= 1'b0;
            kn_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            flip_pend_q <= flip_pend_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            kf_q        <= (state_d == FLIP);
            kfd_q       <= (state_d == FLIP_D);
            kn_q        <= (state_d == NXT);
        end
    end

    assign key_flip   = kf_q;
    assign key_flip_d = kfd_q;
    assign key_nxt    = kn_q;
    assign cursor_x   = cx_q;
    assign cursor_y   = cy_q;

endmodule
